get_height_core: RTL and testbench
==================================

GET_HEIGHT_CORE -- requirements
Module: get_height

Interface
REQ-001 Parameter SAMPLE_DIV, default 1000: clk cycles per mic sample tick (range 1..65535).
REQ-002 Parameter AMP_THRESH, default 32: minimum peak-to-peak window amplitude (12-bit units) for a valid pitch.
REQ-003 Parameter HEIGHT_SHIFT, default 4: left shift applied to the crossing count to form height.
REQ-004 clk  input  1  single system clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 mic_data  input  12  unsigned microphone sample, sampled only on sample ticks.
REQ-007 height  output  10  unsigned registered pitch height; 0 = silence/ground.

Function
REQ-008 Divider counter SHALL count 0..SAMPLE_DIV-1 and wrap; a sample tick SHALL occur in the cycle the counter equals SAMPLE_DIV-1; with SAMPLE_DIV=1 every cycle is a tick; the divider SHALL run in all states.
REQ-009 FSM states SHALL be COLLECT, MEAN, COUNT, UPDATE; reset state COLLECT.
REQ-010 COLLECT: on each tick, store mic_data into buffer[idx] (64 x 12 bit), add to an 18-bit sum, update running min/max, increment 6-bit idx.
REQ-011 After the 64th stored sample (idx wraps 63->0), go to MEAN on the next cycle.
REQ-012 MEAN (1 cycle): mean = sum >> 6 (12 bit); range = max - min; go to COUNT.
REQ-013 COUNT (63 cycles, i = 1..63): crossing when (buffer[i-1] >= mean) != (buffer[i] >= mean); 6-bit crossing counter, max 63, no overflow possible.
REQ-014 UPDATE (1 cycle): raw = 0 if range < AMP_THRESH, else crossings << HEIGHT_SHIFT saturated to 1023; height register loads per REQ-020; then clear sum/idx, min = 4095, max = 0, return to COLLECT.
REQ-015 Ticks during MEAN/COUNT/UPDATE SHALL be discarded; a tick in the same cycle as the COLLECT entry is accepted.
REQ-016 height SHALL change only at the end of UPDATE and hold otherwise.
REQ-017 Latency: height updates exactly 65 cycles after the clock edge that stores the 64th sample.

Reset
REQ-018 While reset = 0: height = 0, divider = 0, idx = 0, sum = 0, min = 4095, max = 0, crossings = 0, state COLLECT; buffer contents need not be cleared.
REQ-019 Reset asserted mid-window (any state) SHALL abort the window; after release, collection restarts from sample 0 and the first tick occurs SAMPLE_DIV cycles after release.

Configuration
REQ-020 Macro GET_HEIGHT_SMOOTH_EN: defined -> in UPDATE, height = (height + raw) >> 1 using an 11-bit sum; undefined -> height = raw.

Verification
REQ-021 Hold reset = 0 for 2 cycles with mic_data = 100 -> height = 0 throughout and after release until the first UPDATE.
REQ-022 SAMPLE_DIV = 1, mic_data = 0,1,...,63 on consecutive ticks -> mean = 31, 1 crossing, height = 16 (smoothing off) / 8 (smoothing on, from 0).
REQ-023 SAMPLE_DIV = 1, constant 2048 for 64 ticks -> range 0 < 32, height = 0.
REQ-024 SAMPLE_DIV = 1, alternating 0/4095 each tick -> 63 crossings, height = 1008 (smoothing off).
REQ-025 SAMPLE_DIV = 1, 4 ticks at 0 then 4 at 4095, repeated -> 15 crossings, height = 240 off / 120 on (from 0); second identical window on -> 180.
REQ-026 Assert reset after 30 samples of the REQ-024 stream, release, then feed the REQ-022 ramp -> height stays 0 until the first UPDATE, then 16 (off); no partial-window result.

Source files
------------

// File: rtl/get_height_core.sv
// -----------------------------------------------------------------------------
// get_height_core
//
// Estimates voice pitch from a microphone stream and turns it into a height
// value. Each window holds 64 samples. The module averages the window, then
// counts how often consecutive samples cross that mean. The crossing count,
// shifted left, becomes the height. A window whose peak-to-peak amplitude is
// too small is treated as silence and gives height 0.
//
// Parameters
//   SAMPLE_DIV   : clk cycles per mic sample tick (1..65535)
//   AMP_THRESH   : minimum peak-to-peak window amplitude for a valid pitch
//   HEIGHT_SHIFT : left shift applied to the crossing count
//
// Ports
//   clk      in   1   system clock, rising edge
//   reset    in   1   asynchronous reset, active low
//   mic_data in  12   unsigned microphone sample, taken on sample ticks only
//   height   out 10   registered pitch height, 0 = silence/ground
//
// Configuration
//   GET_HEIGHT_SMOOTH_EN : when defined, each new height is the average of
//                          the previous height and the new raw value.
// -----------------------------------------------------------------------------
module get_height_core #(
    parameter int SAMPLE_DIV   = 1000,
    parameter int AMP_THRESH   = 32,
    parameter int HEIGHT_SHIFT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] mic_data,
    output logic [9:0]  height
);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        MEAN    = 2'd1,
        COUNT   = 2'd2,
        UPDATE  = 2'd3
    } state_t;

    localparam logic [15:0] DIV_LAST = 16'(SAMPLE_DIV - 1);
    localparam logic [31:0] AMP_W    = 32'(AMP_THRESH);

    // Shift the crossing count into a height and clamp it to the 10-bit range.
    function automatic logic [9:0] sat_height(input logic [5:0] crossings);
        logic [63:0] wide;
        begin
            wide = {58'd0, crossings} << HEIGHT_SHIFT;
            if (wide > 64'd1023) begin
                sat_height = 10'd1023;
            end else begin
                sat_height = wide[9:0];
            end
        end
    endfunction

    state_t      state_r;
    state_t      state_next_s;

    logic [15:0] div_cnt_r;
    logic        tick_s;

    logic [11:0] sample_mem_r [64];
    logic [5:0]  idx_r;
    logic [17:0] sum_r;
    logic [11:0] min_r;
    logic [11:0] max_r;
    logic [11:0] mean_r;
    logic [11:0] range_r;
    logic [5:0]  pos_r;
    logic [5:0]  cross_r;
    logic [9:0]  height_r;

    logic        collect_en_s;
    logic        mean_en_s;
    logic        count_en_s;
    logic        update_en_s;

    logic [11:0] prev_smp_s;
    logic [11:0] cur_smp_s;
    logic        crossing_s;
    logic [9:0]  raw_s;
    logic [9:0]  height_next_s;

    assign tick_s = (div_cnt_r == DIV_LAST);

    // Sample-rate divider; it keeps running in every state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt_r <= 16'd0;
        end else if (tick_s) begin
            div_cnt_r <= 16'd0;
        end else begin
            div_cnt_r <= div_cnt_r + 16'd1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= COLLECT;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            COLLECT: begin
                if (tick_s && (idx_r == 6'd63)) begin
                    state_next_s = MEAN;
                end else begin
                    state_next_s = COLLECT;
                end
            end
            MEAN:    state_next_s = COUNT;
            COUNT: begin
                if (pos_r == 6'd63) begin
                    state_next_s = UPDATE;
                end else begin
                    state_next_s = COUNT;
                end
            end
            UPDATE:  state_next_s = COLLECT;
            default: state_next_s = COLLECT;
        endcase
    end

    // FSM output decode. Ticks outside COLLECT are ignored.
    always_comb begin
        collect_en_s = 1'b0;
        mean_en_s    = 1'b0;
        count_en_s   = 1'b0;
        update_en_s  = 1'b0;
        case (state_r)
            COLLECT: collect_en_s = tick_s;
            MEAN:    mean_en_s    = 1'b1;
            COUNT:   count_en_s   = 1'b1;
            UPDATE:  update_en_s  = 1'b1;
            default: collect_en_s = 1'b0;
        endcase
    end

    // Sample buffer. It is left without reset because every entry is
    // rewritten before the next window reads it.
    always_ff @(posedge clk) begin
        if (collect_en_s) begin
            sample_mem_r[idx_r] <= mic_data;
        end
    end

    // Crossing detection between adjacent buffered samples.
    always_comb begin
        prev_smp_s = sample_mem_r[pos_r - 6'd1];
        cur_smp_s  = sample_mem_r[pos_r];
        crossing_s = (prev_smp_s >= mean_r) != (cur_smp_s >= mean_r);
    end

    // Raw height, gated by amplitude, plus the optional smoothing.
    always_comb begin
        if ({20'd0, range_r} < AMP_W) begin
            raw_s = 10'd0;
        end else begin
            raw_s = sat_height(cross_r);
        end
`ifdef GET_HEIGHT_SMOOTH_EN
        height_next_s = 10'(({1'b0, height_r} + {1'b0, raw_s}) >> 1);
`else
        height_next_s = raw_s;
`endif
    end

    // Window datapath: accumulate, compute mean and range, count crossings,
    // and publish the height.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_r    <= 6'd0;
            sum_r    <= 18'd0;
            min_r    <= 12'd4095;
            max_r    <= 12'd0;
            mean_r   <= 12'd0;
            range_r  <= 12'd0;
            pos_r    <= 6'd0;
            cross_r  <= 6'd0;
            height_r <= 10'd0;
        end else if (collect_en_s) begin
            idx_r <= idx_r + 6'd1;
            sum_r <= sum_r + {6'd0, mic_data};
            min_r <= (mic_data < min_r) ? mic_data : min_r;
            max_r <= (mic_data > max_r) ? mic_data : max_r;
        end else if (mean_en_s) begin
            mean_r  <= 12'(sum_r >> 6);
            range_r <= max_r - min_r;
            pos_r   <= 6'd1;
            cross_r <= 6'd0;
        end else if (count_en_s) begin
            // At most 63 crossings fit in 64 samples, so the counter cannot wrap.
            if (crossing_s) begin
                cross_r <= cross_r + 6'd1;
            end else begin
                cross_r <= cross_r;
            end
            pos_r <= pos_r + 6'd1;
        end else if (update_en_s) begin
            height_r <= height_next_s;
            idx_r    <= 6'd0;
            sum_r    <= 18'd0;
            min_r    <= 12'd4095;
            max_r    <= 12'd0;
        end else begin
            idx_r <= idx_r;
        end
    end

    assign height = height_r;

endmodule

// File: tb/tb_get_height_core.sv
// -----------------------------------------------------------------------------
// tb_get_height_core
//
// Directed bench for get_height_core. Two instances with SAMPLE_DIV = 1 share
// the same stimulus. Instance A uses the default shift of 4. Instance B uses a
// shift of 5 so that the alternating pattern drives it into saturation.
// Expected heights are worked out by hand, for both smoothing builds.
// -----------------------------------------------------------------------------
module tb_get_height_core;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] mic_data;
    logic [9:0]  height_a;
    logic [9:0]  height_b;

    logic [9:0]  exp_a;
    logic [9:0]  exp_b;

    int checks = 0;
    int passed = 0;
    int failed = 0;

    get_height_core #(.SAMPLE_DIV(1), .AMP_THRESH(32), .HEIGHT_SHIFT(4)) dut_a (
        .clk      (clk),
        .reset    (reset),
        .mic_data (mic_data),
        .height   (height_a)
    );

    get_height_core #(.SAMPLE_DIV(1), .AMP_THRESH(32), .HEIGHT_SHIFT(5)) dut_b (
        .clk      (clk),
        .reset    (reset),
        .mic_data (mic_data),
        .height   (height_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] expv);
        checks++;
        assert (obs === expv) passed++;
        else begin
            failed++;
            $error("FAIL %s: height=%0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic check_both(input string tag);
        check({tag, "_a"}, height_a, exp_a);
        check({tag, "_b"}, height_b, exp_b);
    endtask

    // 0: ramp, 1: constant 2048, 2: alternating 0/4095, 3: blocks of 4.
    function automatic logic [11:0] pattern(input int mode, input int k);
        case (mode)
            0:       pattern = 12'(k);
            1:       pattern = 12'd2048;
            2:       pattern = ((k % 2) == 1) ? 12'd4095 : 12'd0;
            3:       pattern = (((k / 4) % 2) == 1) ? 12'd4095 : 12'd0;
            default: pattern = 12'd0;
        endcase
    endfunction

    // Feed one window, then check that height holds for 64 cycles after the
    // 64th sample and changes to the new value on the 65th.
    task automatic run_window(input int mode, input logic [9:0] new_a,
                              input logic [9:0] new_b, input string tag);
        for (int k = 0; k < 64; k++) begin
            mic_data = pattern(mode, k);
            @(negedge clk);
            check_both({tag, "_hold_in"});
        end
        mic_data = 12'hABC;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            check_both({tag, "_hold_wait"});
        end
        @(negedge clk);
        exp_a = new_a;
        exp_b = new_b;
        check_both({tag, "_result"});
    endtask

    initial begin
        reset    = 1'b0;
        mic_data = 12'd100;
        exp_a    = 10'd0;
        exp_b    = 10'd0;

        // Reset held for 2 cycles.
        repeat (2) begin
            @(negedge clk);
            check_both("reset");
        end
        reset = 1'b1;

`ifdef GET_HEIGHT_SMOOTH_EN
        run_window(0, 10'd8,   10'd16,  "ramp");
        run_window(1, 10'd4,   10'd8,   "const");
        run_window(2, 10'd506, 10'd515, "alt");
`else
        run_window(0, 10'd16,   10'd32,   "ramp");
        run_window(1, 10'd0,    10'd0,    "const");
        run_window(2, 10'd1008, 10'd1023, "alt");
`endif

        // Abort after 30 samples of the alternating stream.
        for (int k = 0; k < 30; k++) begin
            mic_data = pattern(2, k);
            @(negedge clk);
            check_both("abort_pre");
        end
        reset = 1'b0;
        exp_a = 10'd0;
        exp_b = 10'd0;
        repeat (2) begin
            @(negedge clk);
            check_both("abort_reset");
        end
        reset = 1'b1;
`ifdef GET_HEIGHT_SMOOTH_EN
        run_window(0, 10'd8,  10'd16, "abort_ramp");
`else
        run_window(0, 10'd16, 10'd32, "abort_ramp");
`endif

        // Clear the height, then run two identical block-of-4 windows.
        reset = 1'b0;
        exp_a = 10'd0;
        exp_b = 10'd0;
        @(negedge clk);
        check_both("blk_reset");
        reset = 1'b1;
`ifdef GET_HEIGHT_SMOOTH_EN
        run_window(3, 10'd120, 10'd240, "blk1");
        run_window(3, 10'd180, 10'd360, "blk2");
`else
        run_window(3, 10'd240, 10'd480, "blk1");
        run_window(3, 10'd240, 10'd480, "blk2");
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
